regfile_wb_scheduler: RTL

Write-back scheduler for the 32x32 register file. Two producers share the file's single write port (WE3/A3/WD3): the ALU path and the load/memory path. The block arbitrates between them with bounded starvation, registers the winning write, and keeps a per-register pending scoreboard so issue logic can stall on RAW and WAW hazards. It sits between the execute/memory stages and the register file write port.

---
 rtl/regfile_wb_scheduler.sv | 112 +++++++++++
 1 files changed

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: arbitrates the ALU and load producers onto the register-file write port and keeps per-register pending bits for hazard stalls.
// Latency: a request accepted at edge N drives rf_we in cycle N+1, and the register is written and its pending bit cleared at edge N+1.
// Backpressure: the output stage never stalls. Exactly one request is granted per cycle whenever either valid is high, and ready is combinational.
//
// Ports:
//   clk, reset                      clock; asynchronous active-high reset
//   alu_valid/alu_rd/alu_data/alu_ready   ALU write-back request
//   mem_valid/mem_rd/mem_data/mem_ready   load write-back request
//   issue_valid/issue_rd            marks issue_rd pending on issue
//   rs1/rs2 -> rs1_busy/rs2_busy, issue_rd -> rd_busy   pending lookups
//   rf_we/rf_a3/rf_wd3              registered register-file write port
module regfile_wb_scheduler #(
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        mem_valid,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   output logic        mem_ready,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        rs1_busy,
   output logic        rs2_busy,
   output logic        rd_busy,
   output logic        rf_we,
   output logic [4:0]  rf_a3,
   output logic [31:0] rf_wd3
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0]  starve_cnt;
   logic [31:0] pending;
   logic [31:0] pending_next;
   logic        grant_alu;
   logic        grant_mem;
   logic [4:0]  grant_rd;
   logic [31:0] grant_data;

   // Loads win on conflict because they are harder to replay.
   // The ALU is forced through once it has lost STARVE_MAX times in a row.
   always_comb begin
      grant_alu  = alu_valid && (!mem_valid || (starve_cnt == STARVE_LIM));
      grant_mem  = mem_valid && !grant_alu;
      grant_rd   = grant_alu ? alu_rd   : mem_rd;
      grant_data = grant_alu ? alu_data : mem_data;
   end

   assign alu_ready = grant_alu;
   assign mem_ready = grant_mem;

   // The counter counts only losses while the ALU is actually waiting.
   // It cannot pass STARVE_LIM, because at the limit the ALU wins and the counter clears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= 4'd0;
      end else if (alu_valid && grant_mem) begin
         starve_cnt <= starve_cnt + 4'd1;
      end else begin
         starve_cnt <= 4'd0;
      end
   end

   // A write to x0 completes its handshake but never pulses rf_we.
   // Address and data hold their last values when nothing is granted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_we  <= 1'b0;
         rf_a3  <= 5'd0;
         rf_wd3 <= 32'd0;
      end else begin
         rf_we <= (grant_alu || grant_mem) && (grant_rd != 5'd0);
         if (grant_alu || grant_mem) begin
            rf_a3  <= grant_rd;
            rf_wd3 <= grant_data;
         end
      end
   end

   // Clear is applied before set, so a same-edge issue to the register being written keeps it pending.
   always_comb begin
      pending_next = pending;
      if (rf_we) begin
         pending_next[rf_a3] = 1'b0;
      end
      if (issue_valid && (issue_rd != 5'd0)) begin
         pending_next[issue_rd] = 1'b1;
      end
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= 32'd0;
      end else begin
         pending <= pending_next;
      end
   end

   // Busy outputs read the stored pending bits directly and do not bypass a same-cycle issue.
   assign rs1_busy = pending[rs1];
   assign rs2_busy = pending[rs2];
   assign rd_busy  = pending[issue_rd];

endmodule
